caxi4interconnect_decode_error_responder: RTL and testbench



---
 rtl/caxi4interconnect_pkg.sv | 17 +
 rtl/caxi4interconnect_decode_error_read_channel.sv | 94 +++++++++
 rtl/caxi4interconnect_decode_error_responder.sv | 123 ++++++++++++
 tb/tb_caxi4interconnect_decode_error_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/caxi4interconnect_pkg.sv
// Shared AXI4 interconnect definitions: response codes and decode-error responder FSM encodings.
package caxi4interconnect_pkg;

  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/caxi4interconnect_decode_error_read_channel.sv
// AR/R half of the decode-error responder: one burst at a time, ARLEN+1 DECERR beats.
// First beat one cycle after AR; RREADY low holds every R output stable.
module caxi4interconnect_decode_error_read_channel #(
  parameter int ID_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [7:0]          arlen,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready
);
  import caxi4interconnect_pkg::*;

  rd_state_e           state_q, state_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]          cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    cnt_d     = cnt_q;
    case (state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rid_d     = arid;
          cnt_d     = arlen;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rresp_d   = RESP_DECERR;
          rlast_d   = (arlen == 8'd0);
          state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (rvalid_q && rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rresp_d   = 2'b00;
            arready_d = 1'b1;
            state_d   = R_IDLE;
          end else begin
            // RLAST is registered, so it must reflect the count after this decrement
            cnt_d   = cnt_q - 8'd1;
            rlast_d = (cnt_q == 8'd1);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rid_q     <= '0;
      cnt_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rid     = rid_q;

endmodule

// File: rtl/caxi4interconnect_decode_error_responder.sv
// AXI4 terminator for unmapped addresses: sinks W beats to WLAST, answers B/R with DECERR.
// One outstanding burst per direction; B/R outputs hold stable while BREADY/RREADY are low.
module caxi4interconnect_decode_error_responder #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 1
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic [ID_WIDTH-1:0]   AWID,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [ID_WIDTH-1:0]   BID,
  output logic [1:0]            BRESP,
  output logic [USER_WIDTH-1:0] BUSER,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ID_WIDTH-1:0]   ARID,
  input  logic [7:0]            ARLEN,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic [USER_WIDTH-1:0] RUSER,
  output logic                  RVALID,
  input  logic                  RREADY
);
  import caxi4interconnect_pkg::*;

  wr_state_e           wstate_q, wstate_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (AWVALID && awready_q) begin
          bid_d     = AWID;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        // Burst length comes from WLAST alone; AWLEN is never seen here
        if (WVALID && wready_q && WLAST) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = RESP_DECERR;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_q && BREADY) begin
          bvalid_d  = 1'b0;
          bresp_d   = 2'b00;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (sysReset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= '0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = bid_q;
  assign BUSER   = '0;
  assign RDATA   = '0;
  assign RUSER   = '0;

  caxi4interconnect_decode_error_read_channel #(
    .ID_WIDTH (ID_WIDTH)
  ) u_read_channel (
    .clk     (ACLK),
    .rst     (sysReset),
    .arid    (ARID),
    .arlen   (ARLEN),
    .arvalid (ARVALID),
    .arready (ARREADY),
    .rid     (RID),
    .rresp   (RRESP),
    .rlast   (RLAST),
    .rvalid  (RVALID),
    .rready  (RREADY)
  );

endmodule

// File: tb/tb_caxi4interconnect_decode_error_responder.sv
// Bench for the decode-error responder: transaction-level model compared every cycle, plus directed literal checks.
module tb_caxi4interconnect_decode_error_responder;
  logic        ACLK = 1'b0;
  logic        sysReset;
  logic [3:0]  AWID, BID, ARID, RID;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic [1:0]  BRESP, RRESP;
  logic [0:0]  BUSER, RUSER;
  logic        BVALID, BREADY;
  logic [7:0]  ARLEN;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [63:0] RDATA;

  always #5 ACLK = ~ACLK;

  caxi4interconnect_decode_error_responder dut (
    .ACLK(ACLK), .sysReset(sysReset),
    .AWID(AWID), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BUSER(BUSER), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RUSER(RUSER),
    .RVALID(RVALID), .RREADY(RREADY)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: is a write open, has its data finished, how many read beats remain.
  bit       m_valid = 1'b0;
  bit       m_fresh, m_w_busy, m_w_done;
  logic [3:0] m_bid, m_rid;
  int       m_r_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    bit rv, bv;
    if (!m_valid) return;
    rv = (m_r_left > 0);
    bv = m_w_busy && m_w_done;
    chk("m_awready", 64'(AWREADY), 64'(!m_fresh && !m_w_busy));
    chk("m_wready",  64'(WREADY),  64'(m_w_busy && !m_w_done));
    chk("m_bvalid",  64'(BVALID),  64'(bv));
    chk("m_bid",     64'(BID),     64'(m_bid));
    chk("m_buser",   64'(BUSER),   64'(0));
    if (bv || m_fresh) chk("m_bresp", 64'(BRESP), bv ? 64'(3) : 64'(0));
    chk("m_arready", 64'(ARREADY), 64'(!m_fresh && m_r_left == 0));
    chk("m_rvalid",  64'(RVALID),  64'(rv));
    chk("m_rid",     64'(RID),     64'(m_rid));
    chk("m_rdata",   RDATA,        64'(0));
    chk("m_ruser",   64'(RUSER),   64'(0));
    if (rv || m_fresh) begin
      chk("m_rresp", 64'(RRESP), rv ? 64'(3) : 64'(0));
      chk("m_rlast", 64'(RLAST), 64'(m_r_left == 1));
    end
  endtask

  task automatic model_step();
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    m_valid = 1'b1;
    if (sysReset) begin
      m_fresh = 1'b1; m_w_busy = 1'b0; m_w_done = 1'b0;
      m_r_left = 0; m_bid = '0; m_rid = '0;
      return;
    end
    aw_hs = AWVALID && !m_fresh && !m_w_busy;
    w_hs  = WVALID && m_w_busy && !m_w_done;
    b_hs  = BREADY && m_w_busy && m_w_done;
    ar_hs = ARVALID && !m_fresh && m_r_left == 0;
    r_hs  = RREADY && m_r_left > 0;
    m_fresh = 1'b0;
    if (aw_hs) begin m_w_busy = 1'b1; m_w_done = 1'b0; m_bid = AWID; end
    if (w_hs && WLAST) m_w_done = 1'b1;
    if (b_hs) begin m_w_busy = 1'b0; m_w_done = 1'b0; end
    if (ar_hs) begin m_r_left = int'(ARLEN) + 1; m_rid = ARID; end
    if (r_hs) m_r_left--;
  endtask

  task automatic tick();
    @(negedge ACLK);
    model_compare();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  int beats, lasts, last_idx, wb, bseen;

  initial begin
    sysReset = 1'b1;
    AWID = '0; AWVALID = 1'b0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset held for three edges, outputs all zero
    @(posedge ACLK); model_step(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_awready", 64'(AWREADY), 64'(0));
      chk("rst_arready", 64'(ARREADY), 64'(0));
      chk("rst_valids",  64'({WREADY, BVALID, RVALID, RLAST}), 64'(0));
      chk("rst_resps",   64'({BRESP, RRESP}), 64'(0));
      if (i < 2) tick();
    end
    sysReset = 1'b0;
    tick();
    chk("rel_awready", 64'(AWREADY), 64'(1));
    chk("rel_arready", 64'(ARREADY), 64'(1));

    // Single-beat write, ID 5
    BREADY = 1'b1; AWID = 4'h5; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("w1_wready", 64'(WREADY), 64'(1));
    chk("w1_awready_lo", 64'(AWREADY), 64'(0));
    WVALID = 1'b1; WLAST = 1'b1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("w1_bvalid", 64'(BVALID), 64'(1));
    chk("w1_bid", 64'(BID), 64'(5));
    chk("w1_bresp", 64'(BRESP), 64'(3));
    chk("w1_wready_lo", 64'(WREADY), 64'(0));
    tick();
    chk("w1_awready_back", 64'(AWREADY), 64'(1));
    chk("w1_bvalid_lo", 64'(BVALID), 64'(0));

    // Four-beat write, BREADY held low while a second AW waits
    BREADY = 1'b0; AWID = 4'h3; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    for (int b = 0; b < 4; b++) begin
      WVALID = 1'b1; WLAST = (b == 3);
      chk("w4_wready", 64'(WREADY), 64'(1));
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0; AWID = 4'h9; AWVALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("w4_bvalid_hold", 64'(BVALID), 64'(1));
      chk("w4_bid_hold", 64'(BID), 64'(3));
      chk("w4_aw_blocked", 64'(AWREADY), 64'(0));
      tick();
    end
    BREADY = 1'b1;
    tick();
    chk("w4_awready_back", 64'(AWREADY), 64'(1));
    tick();
    AWVALID = 1'b0;
    chk("w5_wready", 64'(WREADY), 64'(1));
    WVALID = 1'b1; WLAST = 1'b1;
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("w5_bid", 64'(BID), 64'(9));
    tick();
    chk("w5_bvalid_lo", 64'(BVALID), 64'(0));

    // Read ARLEN=3 with RREADY alternating
    ARID = 4'hA; ARLEN = 8'd3; ARVALID = 1'b1; RREADY = 1'b0;
    tick();
    ARVALID = 1'b0;
    chk("r4_rvalid", 64'(RVALID), 64'(1));
    beats = 0; lasts = 0; last_idx = 0;
    for (int c = 0; c < 40 && !(ARREADY && !RVALID); c++) begin
      RREADY = (c % 2 == 0);
      if (RVALID && RREADY) begin
        beats++;
        if (RLAST) begin lasts++; last_idx = beats; end
        chk("r4_rid", 64'(RID), 64'(4'hA));
        chk("r4_rresp", 64'(RRESP), 64'(3));
      end
      tick();
    end
    chk("r4_beats", 64'(beats), 64'(4));
    chk("r4_lasts", 64'(lasts), 64'(1));
    chk("r4_last_idx", 64'(last_idx), 64'(4));
    chk("r4_arready", 64'(ARREADY), 64'(1));

    // ARLEN=255 with a concurrent write
    RREADY = 1'b1; BREADY = 1'b1;
    ARID = 4'h7; ARLEN = 8'd255; ARVALID = 1'b1; AWID = 4'hC; AWVALID = 1'b1;
    tick();
    ARVALID = 1'b0; AWVALID = 1'b0;
    chk("r256_rvalid", 64'(RVALID), 64'(1));
    chk("r256_wready", 64'(WREADY), 64'(1));
    beats = 0; lasts = 0; last_idx = 0; wb = 0; bseen = 0;
    for (int c = 0; c < 400 && !(ARREADY && !RVALID); c++) begin
      WVALID = (wb < 2); WLAST = (wb == 1);
      if (WVALID && WREADY) wb++;
      if (BVALID && BREADY) begin bseen++; chk("r256_bid", 64'(BID), 64'(4'hC)); end
      if (RVALID && RREADY) begin
        beats++;
        if (RLAST) begin lasts++; last_idx = beats; end
      end
      tick();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    chk("r256_beats", 64'(beats), 64'(256));
    chk("r256_lasts", 64'(lasts), 64'(1));
    chk("r256_last_idx", 64'(last_idx), 64'(256));
    chk("r256_bseen", 64'(bseen), 64'(1));
    chk("r256_awready", 64'(AWREADY), 64'(1));

    // Reset during beat 2 of an ARLEN=7 read
    ARID = 4'h2; ARLEN = 8'd7; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    tick();
    chk("rr_beat2_valid", 64'(RVALID), 64'(1));
    chk("rr_beat2_nolast", 64'(RLAST), 64'(0));
    sysReset = 1'b1;
    tick();
    sysReset = 1'b0;
    chk("rr_rvalid_lo", 64'(RVALID), 64'(0));
    chk("rr_arready_lo", 64'(ARREADY), 64'(0));
    tick();
    chk("rr_arready_back", 64'(ARREADY), 64'(1));
    ARID = 4'hE; ARLEN = 8'd0; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("rr_one_rvalid", 64'(RVALID), 64'(1));
    chk("rr_one_rlast", 64'(RLAST), 64'(1));
    chk("rr_one_rid", 64'(RID), 64'(4'hE));
    tick();
    chk("rr_done_rvalid", 64'(RVALID), 64'(0));
    chk("rr_done_arready", 64'(ARREADY), 64'(1));

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      sysReset = ($urandom_range(0, 299) == 0);
      AWID    = 4'($urandom_range(0, 15));
      AWVALID = 1'($urandom_range(0, 1));
      WVALID  = 1'($urandom_range(0, 1));
      WLAST   = ($urandom_range(0, 2) == 0);
      BREADY  = 1'($urandom_range(0, 1));
      ARID    = 4'($urandom_range(0, 15));
      ARLEN   = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
      ARVALID = 1'($urandom_range(0, 1));
      RREADY  = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
